scandoubler_vidmem_arbiter: RTL and testbench

Arbitrates the scandoubler rotation path's two memory requesters onto one burst-oriented SDRAM port. The requesters are the write stream (`vidin_*`, 16-word bursts) and the read stream (`vidout_*`, 8-word bursts). Sits between the scandoubler top level and the system memory controller. Forms linear word addresses from frame/row/col, sequences bursts and steers per-word acknowledges and data. Reads get priority, with a bounded-run rule so writes cannot starve.

---
 rtl/scandoubler_vidmem_arbiter_if.sv | 57 +++++
 rtl/scandoubler_vidmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_scandoubler_vidmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scandoubler_vidmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : scandoubler_vidmem_arbiter_if
// Description : Bundles the write requester (vidin_*), the read requester
//               (vidout_*) and the burst SDRAM port (mem_*) seen by the
//               scandoubler video-memory arbiter.
//               master : arbiter view (drives acks, read data, mem request)
//               slave  : environment view (requesters + memory controller)
// Ports       : vidin_req/frame/row/col/d, vidin_ack
//               vidout_req/frame/row/col, vidout_d, vidout_ack
//               mem_req, mem_we, mem_addr, mem_len, mem_d, mem_q, mem_ack
// Revision    : 1.0 - initial release
// ============================================================================
interface scandoubler_vidmem_arbiter_if #(
  parameter int ADDR_WIDTH = 25
);
  logic                  vidin_req;
  logic [1:0]            vidin_frame;
  logic [10:0]           vidin_row;
  logic [10:0]           vidin_col;
  logic [15:0]           vidin_d;
  logic                  vidin_ack;

  logic                  vidout_req;
  logic [1:0]            vidout_frame;
  logic [10:0]           vidout_row;
  logic [10:0]           vidout_col;
  logic [15:0]           vidout_d;
  logic                  vidout_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [4:0]            mem_len;
  logic [15:0]           mem_d;
  logic [15:0]           mem_q;
  logic                  mem_ack;

  modport master (
    input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidin_ack,
    input  vidout_req, vidout_frame, vidout_row, vidout_col,
    output vidout_d, vidout_ack,
    output mem_req, mem_we, mem_addr, mem_len, mem_d,
    input  mem_q, mem_ack
  );

  modport slave (
    output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidin_ack,
    output vidout_req, vidout_frame, vidout_row, vidout_col,
    input  vidout_d, vidout_ack,
    input  mem_req, mem_we, mem_addr, mem_len, mem_d,
    output mem_q, mem_ack
  );
endinterface
`default_nettype wire

// File: rtl/scandoubler_vidmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : scandoubler_vidmem_arbiter
// Description : Arbitrates the scandoubler write stream (WR_BURST-word bursts)
//               and read stream (RD_BURST-word bursts) onto one burst SDRAM
//               port. Reads win, but at most MAX_RD_RUN read bursts are
//               granted back-to-back while a write is waiting.
// Ports       : clk_sys  - system clock
//               reset_n  - asynchronous active-low reset
//               bus      - master view of the requester / memory bundle
// Revision    : 1.0 - initial release
// ============================================================================
module scandoubler_vidmem_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int BASE_ADDR  = 0,
  parameter int WR_BURST   = 16,
  parameter int RD_BURST   = 8,
  parameter int MAX_RD_RUN = 4
) (
  input  wire                             clk_sys,
  input  wire                             reset_n,
  scandoubler_vidmem_arbiter_if.master    bus
);

  localparam int         RUN_W   = $clog2(MAX_RD_RUN + 1);
  localparam logic [4:0] WR_LEN  = 5'(WR_BURST);
  localparam logic [4:0] RD_LEN  = 5'(RD_BURST);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RD_RUN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [4:0]        cnt, cnt_nx;
  logic [RUN_W-1:0]  rd_run, rd_run_nx;
  logic              grant_rd, grant_wr;

  // Linear word address: {frame,row,col} zero-extended, offset, truncated.
  logic [23:0]           wr_lin, rd_lin;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

  assign wr_lin  = {bus.vidin_frame,  bus.vidin_row,  bus.vidin_col};
  assign rd_lin  = {bus.vidout_frame, bus.vidout_row, bus.vidout_col};
  assign wr_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(wr_lin);
  assign rd_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(rd_lin);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, word counter, read-run counter and bus decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    rd_run_nx     = rd_run;
    grant_rd      = 1'b0;
    grant_wr      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.vidin_ack = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        // A pending write blocks further reads once the run limit is hit.
        if (bus.vidout_req && !(bus.vidin_req && (rd_run == RUN_MAX))) begin
          grant_rd = 1'b1;
          state_nx = S_RD;
        end else if (bus.vidin_req) begin
          grant_wr = 1'b1;
          state_nx = S_WR;
        end

        // The run only counts reads that overtook a waiting write.
        if (!bus.vidin_req || grant_wr) begin
          rd_run_nx = '0;
        end else if (grant_rd && (rd_run != RUN_MAX)) begin
          rd_run_nx = rd_run + 1'b1;
        end
      end

      S_WR: begin
        bus.mem_req   = 1'b1;
        bus.vidin_ack = bus.mem_ack;
        if (bus.mem_ack) begin
          if (cnt == WR_LEN - 5'd1) begin
            cnt_nx   = '0;
            state_nx = S_GAP;
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
      end

      S_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          if (cnt == RD_LEN - 5'd1) begin
            cnt_nx   = '0;
            state_nx = S_GAP;
          end else begin
            cnt_nx = cnt + 5'd1;
          end
        end
      end

      S_GAP: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      rd_run <= '0;
    end else begin
      cnt    <= cnt_nx;
      rd_run <= rd_run_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Burst descriptor, latched at grant and held for the whole burst
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_len  <= '0;
    end else if (grant_rd) begin
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= rd_addr;
      bus.mem_len  <= RD_LEN;
    end else if (grant_wr) begin
      bus.mem_we   <= 1'b1;
      bus.mem_addr <= wr_addr;
      bus.mem_len  <= WR_LEN;
    end
  end

  // --------------------------------------------------------------------------
  // Read return path: one-cycle registered copy of mem_q on each read ack
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.vidout_ack <= 1'b0;
      bus.vidout_d   <= '0;
    end else begin
      bus.vidout_ack <= (state == S_RD) && bus.mem_ack;
      if ((state == S_RD) && bus.mem_ack) begin
        bus.vidout_d <= bus.mem_q;
      end
    end
  end

  // Write data goes straight through; the requester advances on vidin_ack.
  assign bus.mem_d = bus.vidin_d;

endmodule
`default_nettype wire

// File: tb/tb_scandoubler_vidmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_scandoubler_vidmem_arbiter
// Description : Self-checking bench for scandoubler_vidmem_arbiter. A
//               transaction-level model (burst words left, turnaround cycles,
//               read-run count) predicts every output each cycle; directed
//               scenarios pin the model with literal values, then a random
//               phase exercises arbitrary request / ack patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scandoubler_vidmem_arbiter;

  localparam int AW   = 25;
  localparam int BASE = 0;
  localparam int WRB  = 16;
  localparam int RDB  = 8;
  localparam int MAXR = 4;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  scandoubler_vidmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  scandoubler_vidmem_arbiter #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .WR_BURST   (WRB),
    .RD_BURST   (RDB),
    .MAX_RD_RUN (MAXR)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  bit          m_busy = 0;
  bit          m_we   = 0;
  int          m_left = 0;
  int          m_cool = 0;
  int          m_run  = 0;
  logic [31:0] m_addr = 0;
  int          m_len  = 0;
  bit          m_vack = 0;
  logic [15:0] m_vd   = 0;

  function automatic logic [31:0] lin_addr(input int f, input int r, input int c);
    longint a;
    a = longint'(BASE) + longint'(f) * 4194304 + longint'(r) * 2048 + longint'(c);
    a = a % (longint'(1) << AW);
    return 32'(a);
  endfunction

  always @(negedge clk_sys) begin
    bit          nv;
    logic [15:0] nd;
    if (!reset_n) begin
      check("rst_mem_req",    32'(bus.mem_req),    0);
      check("rst_mem_we",     32'(bus.mem_we),     0);
      check("rst_mem_addr",   32'(bus.mem_addr),   0);
      check("rst_mem_len",    32'(bus.mem_len),    0);
      check("rst_vidin_ack",  32'(bus.vidin_ack),  0);
      check("rst_vidout_ack", 32'(bus.vidout_ack), 0);
      check("rst_vidout_d",   32'(bus.vidout_d),   0);
      m_busy = 0; m_left = 0; m_cool = 0; m_run = 0; m_vack = 0;
    end else begin
      check("mem_req", 32'(bus.mem_req), 32'(m_busy));
      if (m_busy) begin
        check("mem_we",   32'(bus.mem_we),   32'(m_we));
        check("mem_addr", 32'(bus.mem_addr), m_addr);
        check("mem_len",  32'(bus.mem_len),  32'(m_len));
      end
      check("vidin_ack",  32'(bus.vidin_ack),  32'(m_busy && m_we && bus.mem_ack));
      check("mem_d",      32'(bus.mem_d),      32'(bus.vidin_d));
      check("vidout_ack", 32'(bus.vidout_ack), 32'(m_vack));
      if (m_vack) check("vidout_d", 32'(bus.vidout_d), 32'(m_vd));

      nv = m_busy && !m_we && bus.mem_ack;
      nd = bus.mem_q;
      if (m_busy) begin
        if (bus.mem_ack) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_cool = 1;
          end
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else begin
        if (bus.vidout_req && !(bus.vidin_req && m_run == MAXR)) begin
          m_busy = 1; m_we = 0; m_len = RDB; m_left = RDB;
          m_addr = lin_addr(bus.vidout_frame, bus.vidout_row, bus.vidout_col);
          m_run  = bus.vidin_req ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
        end else if (bus.vidin_req) begin
          m_busy = 1; m_we = 1; m_len = WRB; m_left = WRB;
          m_addr = lin_addr(bus.vidin_frame, bus.vidin_row, bus.vidin_col);
          m_run  = 0;
        end else begin
          m_run = 0;
        end
      end
      m_vack = nv;
      m_vd   = nd;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  int          ack_mode  = 0;   // 0 every cycle, 1 alternate, 2 random
  bit          rand_ph   = 0;
  bit          inc_q     = 0;
  bit          ack_tog   = 0;
  int          rd_words  = 0;
  int          vin_cnt   = 0;
  int          consec    = 0;
  bit          prev_req  = 0;
  bit          grants[$];
  logic [15:0] vout_vals[$];

  task automatic step();
    @(posedge clk_sys);
    #2;
    if (bus.mem_req && !prev_req) begin
      grants.push_back(bus.mem_we);
      if (bus.mem_we) consec = 0;
      else consec = bus.vidin_req ? consec + 1 : 0;
      if (rand_ph) check("read_run_limit", 32'(consec > MAXR), 0);
    end
    prev_req = bus.mem_req;
    ack_tog  = ~ack_tog;
    if (bus.mem_req) begin
      case (ack_mode)
        0:       bus.mem_ack = 1'b1;
        1:       bus.mem_ack = ack_tog;
        default: bus.mem_ack = ($urandom_range(0, 2) != 0);
      endcase
    end else begin
      bus.mem_ack = rand_ph ? ($urandom_range(0, 9) == 0) : 1'b0;
    end
    bus.mem_q   = inc_q ? 16'(16'h100 + rd_words) : 16'($urandom);
    bus.vidin_d = 16'($urandom);
    if (bus.mem_ack && bus.mem_req && !bus.mem_we) rd_words++;
    #1;
    if (bus.vidin_ack)  vin_cnt++;
    if (bus.vidout_ack) vout_vals.push_back(bus.vidout_d);
  endtask

  task automatic wait_grant(input string name);
    int g0;
    bit ok;
    g0 = grants.size();
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (grants.size() > g0) begin ok = 1; break; end
    end
    if (!ok) check({name, "_grant_timeout"}, 1, 0);
  endtask

  task automatic idle(input int n);
    bus.vidin_req  = 1'b0;
    bus.vidout_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  initial begin
    bit ok;
    bus.vidin_req = 0;  bus.vidin_frame = 0;  bus.vidin_row = 0;  bus.vidin_col = 0;
    bus.vidin_d = 0;    bus.vidout_req = 0;   bus.vidout_frame = 0;
    bus.vidout_row = 0; bus.vidout_col = 0;   bus.mem_q = 0;      bus.mem_ack = 0;

    // Reset and quiet idle
    #1;
    check("reset_mem_req",  32'(bus.mem_req),  0);
    check("reset_mem_addr", 32'(bus.mem_addr), 0);
    check("reset_vidout_d", 32'(bus.vidout_d), 0);
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    idle(100);
    check("idle_mem_req", 32'(bus.mem_req), 0);
    check("idle_grants",  32'(grants.size()), 0);

    // Directed write burst
    bus.vidin_frame = 2'd1; bus.vidin_row = 11'd5; bus.vidin_col = 11'd32;
    bus.vidin_req = 1'b1; ack_mode = 0; vin_cnt = 0;
    wait_grant("wr");
    bus.vidin_req = 1'b0;
    check("wr_addr_lit", 32'(bus.mem_addr), 32'h402820);
    check("wr_we_lit",   32'(bus.mem_we),   1);
    check("wr_len_lit",  32'(bus.mem_len),  16);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (vin_cnt >= 16) begin ok = 1; break; end
      step();
    end
    check("wr_ack_timeout", 32'(ok), 1);
    step();
    check("wr_req_drop", 32'(bus.mem_req), 0);
    check("wr_ack_count", 32'(vin_cnt), 16);
    idle(4);

    // Directed read burst with gaps between acks
    bus.vidout_frame = 2'd2; bus.vidout_row = 11'd7; bus.vidout_col = 11'd8;
    bus.vidout_req = 1'b1; ack_mode = 1; inc_q = 1; rd_words = 0;
    vout_vals.delete();
    wait_grant("rd");
    bus.vidout_req = 1'b0;
    check("rd_addr_lit", 32'(bus.mem_addr), 32'h803808);
    check("rd_we_lit",   32'(bus.mem_we),   0);
    check("rd_len_lit",  32'(bus.mem_len),  8);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (vout_vals.size() >= 8) begin ok = 1; break; end
      step();
    end
    check("rd_data_timeout", 32'(ok), 1);
    for (int i = 0; i < 8 && i < vout_vals.size(); i++)
      check($sformatf("rd_word%0d", i), 32'(vout_vals[i]), 32'(16'h100 + i));
    inc_q = 0;
    idle(6);
    check("rd_word_count", 32'(vout_vals.size()), 8);

    // Both requests held: four reads then a write, repeating
    ack_mode = 0;
    grants.delete();
    bus.vidin_req = 1'b1; bus.vidout_req = 1'b1;
    for (int i = 0; i < 2000 && grants.size() < 10; i++) step();
    check("both_grant_count", 32'(grants.size() >= 10), 1);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check($sformatf("both_grant%0d", i), 32'(grants[i]), 32'((i % 5) == 4));
    idle(40);

    // Write requester drops after the third ack
    bus.vidin_req = 1'b1; vin_cnt = 0;
    wait_grant("drop");
    for (int i = 0; i < 100 && vin_cnt < 3; i++) step();
    bus.vidin_req = 1'b0;
    for (int i = 0; i < 100 && vin_cnt < 16; i++) step();
    begin
      int g;
      g = grants.size();
      for (int i = 0; i < 20; i++) step();
      check("drop_no_regrant", 32'(grants.size()), 32'(g));
    end
    check("drop_ack_count", 32'(vin_cnt), 16);

    // Reset during the third read burst, then fresh arbitration
    grants.delete(); rd_words = 0;
    bus.vidin_req = 1'b1; bus.vidout_req = 1'b1;
    for (int i = 0; i < 500 && rd_words < 20; i++) step();
    check("pre_rst_reads", 32'(rd_words), 20);
    reset_n = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check("midrst_mem_req",    32'(bus.mem_req),    0);
    check("midrst_mem_addr",   32'(bus.mem_addr),   0);
    check("midrst_mem_len",    32'(bus.mem_len),    0);
    check("midrst_vidout_ack", 32'(bus.vidout_ack), 0);
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;
    grants.delete();
    for (int i = 0; i < 1000 && grants.size() < 5; i++) step();
    check("postrst_grant_count", 32'(grants.size() >= 5), 1);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check($sformatf("postrst_grant%0d", i), 32'(grants[i]), 32'(i == 4));
    idle(40);

    // Random phase
    rand_ph = 1; ack_mode = 2; consec = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.vidin_req  = ~bus.vidin_req;
      if ($urandom_range(0, 7) == 0) bus.vidout_req = ~bus.vidout_req;
      bus.vidin_frame  = 2'($urandom);  bus.vidin_row  = 11'($urandom);
      bus.vidin_col    = 11'($urandom); bus.vidout_frame = 2'($urandom);
      bus.vidout_row   = 11'($urandom); bus.vidout_col   = 11'($urandom);
      step();
    end
    rand_ph = 0;
    idle(60);
    check("final_idle", 32'(bus.mem_req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
